// File: rtl/parse_pipe.sv
// RISC-V field parser with a registered DEPTH-entry output FIFO (optional counters: PARSE_PIPE_CNT_EN).
// Latency: a word pushed at edge N is at the outputs after edge N when the FIFO was empty, else in FIFO order.
// Backpressure: in_ready = (count != DEPTH); no same-cycle bypass when full; flush beats push and pop.
module parse_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ins,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
`ifdef PARSE_PIPE_CNT_EN
    ,
    output logic [31:0]     pop_cnt,
    output logic [31:0]     illegal_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_SB  = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_UJ  = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd7;

    // Raw word is kept whole; the register fields are just slices of it at the head.
    typedef struct packed {
        logic [31:0]     raw;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t          w_entry;
    entry_t          w_head;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_cnt;

    // Decode format and immediate from the incoming word. Every listed opcode has
    // ins[1:0]==2'b11, so the default arm also catches compressed/invalid low bits.
    always_comb begin
        w_fmt     = FMT_BAD;
        w_imm     = '0;
        w_illegal = 1'b0;
        case (ins[6:0])
            7'b0110011: w_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                w_fmt = FMT_I;
                w_imm = XLEN'($signed(ins[31:20]));
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                w_imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            end
            7'b1100011: begin
                w_fmt = FMT_SB;
                w_imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                w_fmt = FMT_U;
                w_imm = XLEN'($signed({ins[31:12], 12'b0}));
            end
            7'b1101111: begin
                w_fmt = FMT_UJ;
                w_imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            default: begin
                w_fmt     = FMT_BAD;
                w_imm     = '0;
                w_illegal = 1'b1;
            end
        endcase
        w_entry = {ins, w_fmt, w_imm, w_illegal};
    end

    assign in_ready  = (r_cnt != CW'(DEPTH));
    assign out_valid = (r_cnt != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Pointer and occupancy bookkeeping; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Entry storage; cleared on reset so no stale decode survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !flush) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // Drive outputs from the head entry, forced to zero while the FIFO is empty.
    always_comb begin
        w_head = r_mem[r_rptr];
        if (!out_valid) w_head = '0;
        opcode  = w_head.raw[6:0];
        rd      = w_head.raw[11:7];
        funct3  = w_head.raw[14:12];
        rs1     = w_head.raw[19:15];
        rs2     = w_head.raw[24:20];
        funct7  = w_head.raw[31:25];
        fmt     = w_head.fmt;
        imm     = w_head.imm;
        illegal = w_head.illegal;
    end

`ifdef PARSE_PIPE_CNT_EN
    logic [31:0] r_pop_cnt;
    logic [31:0] r_illegal_cnt;

    // Pop statistics; survive flush, wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_cnt     <= '0;
            r_illegal_cnt <= '0;
        end else if (w_pop && !flush) begin
            r_pop_cnt <= r_pop_cnt + 32'd1;
            if (illegal) r_illegal_cnt <= r_illegal_cnt + 32'd1;
        end
    end

    assign pop_cnt     = r_pop_cnt;
    assign illegal_cnt = r_illegal_cnt;
`endif

endmodule
